rr_req_arbiter: RTL and testbench

Round-robin request/grant arbiter that shares one resource among N_REQ requesters using a registered req/gnt handshake. Grant follows request by exactly one cycle (req |=> gnt), is held until the owner drops its request or a hold-timeout expires, and is then re-arbitrated fairly. It sits in front of any shared datapath and is the block our SVA handshake properties are written against.

---
 rtl/rr_arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 26 ++
 rtl/rr_req_arbiter.sv | 77 +++++++
 tb/tb_rr_req_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types, default sizes and counter-width helper for the round-robin arbiter
package rr_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int MAX_HOLD_DEF = 16;
  function automatic int cnt_w(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority picker, first set req bit searching upward from last+1 with wrap
//   req   in  N_REQ  candidate requests
//   last  in  W      index of the previous winner
//   found out 1      any request present
//   win   out W      selected index (0 when none)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     last,
  output logic             found,
  output logic [W-1:0]     win
);
  logic [W-1:0] w_idx;
  // Walk from the farthest offset down to last+1 so the nearest set bit is written last.
  always_comb begin
    found = |req;
    win = '0;
    w_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = W'((int'(last) + k) % N_REQ);
      if (req[w_idx]) win = w_idx;
    end
  end
endmodule

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin req/gnt arbiter with registered grant, owner-release and hold-timeout
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   N_REQ  level requests
//   gnt      out  N_REQ  one-hot-or-zero registered grant
//   gnt_id   out  owner index, valid while busy
//   busy     out  resource owned
//   timeout  out  one-cycle pulse when a grant is force-revoked
//   RR_ARB_ASSERT_EN compiles in the handshake assertions.
module rr_req_arbiter import rr_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout
);
  localparam int W = $clog2(N_REQ);
  localparam int CW = cnt_w(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CW-1:0] HOLD_SAT = CW'(MAX_HOLD);
  state_t r_state, w_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [W-1:0] r_gnt_id, r_last, w_win;
  logic [CW-1:0] r_hold;
  logic r_timeout, w_found, w_own, w_rel, w_to;
  rr_pick #(.N_REQ(N_REQ), .W(W)) u_pick (.req(req), .last(r_last), .found(w_found), .win(w_win));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_gnt_id <= '0;
      r_last <= W'(N_REQ - 1);
      r_hold <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_timeout <= w_to;
      if (r_state == IDLE && w_found) begin
        r_gnt <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
        r_gnt_id <= w_win;
        r_last <= w_win;
        r_hold <= '0;
      end else if (w_rel || w_to) r_gnt <= '0;
      else if (r_state == GRANT && r_hold != HOLD_SAT) r_hold <= r_hold + CW'(1);
    end
  // Release is checked first so a coincident release suppresses the timeout.
  always_comb begin
    w_own = req[r_gnt_id];
    w_rel = r_state == GRANT && !w_own;
    w_to = r_state == GRANT && w_own && MAX_HOLD > 0 && r_hold == HOLD_LAST;
    w_nxt = (r_state == IDLE) ? (w_found ? GRANT : IDLE) : ((w_rel || w_to) ? IDLE : GRANT);
  end
  always_comb begin
    gnt = r_gnt;
    gnt_id = r_gnt_id;
    busy = |r_gnt;
    timeout = r_timeout;
  end
`ifdef RR_ARB_ASSERT_EN
  localparam int BOUND = (N_REQ - 1) * (MAX_HOLD + 1) + 1;
  a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));
  a_idle_grant: assert property (@(posedge clk) disable iff (!reset_n) (r_state == IDLE && |req) |=> busy);
  a_to_idle: assert property (@(posedge clk) disable iff (!reset_n) timeout |-> !busy);
  for (genvar i = 0; i < N_REQ; i++) begin : g_sva
    a_gnt_req: assert property (@(posedge clk) disable iff (!reset_n) $rose(gnt[i]) |-> $past(req[i]));
    if (MAX_HOLD > 0) begin : g_live
      a_live: assert property (@(posedge clk) disable iff (!reset_n) (!busy && req[i]) |-> ##[1:BOUND] gnt[i]);
    end
  end
`else
`endif
endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter: directed checks of grant order, release, timeout and async reset
module tb_rr_req_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic busy, timeout;
  int errors = 0;
  int checks = 0;
  int exp_own[5] = '{0, 1, 2, 3, 0};
  int to_own[3] = '{0, 1, 0};
  always #5 clk = ~clk;
  rr_req_arbiter #(.N_REQ(4), .MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_id", 8'(gnt_id), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_to", 8'(timeout), 8'h0);
    reset_n = 1'b1;
    tick();
    req = 4'b0001;
    #1;
    chk("no_comb", 8'(gnt), 8'h0);
    tick();
    chk("g0_gnt", 8'(gnt), 8'h1);
    chk("g0_id", 8'(gnt_id), 8'h0);
    chk("g0_busy", 8'(busy), 8'h1);
    tick();
    tick();
    chk("g0_hold", 8'(gnt), 8'h1);
    req = 4'b0000;
    tick();
    chk("g0_rel", 8'(gnt), 8'h0);
    chk("g0_relb", 8'(busy), 8'h0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      chk("rr_gnt", 8'(gnt), 8'(1 << exp_own[n]));
      chk("rr_id", 8'(gnt_id), 8'(exp_own[n]));
      tick();
      chk("rr_hold", 8'(gnt), 8'(1 << exp_own[n]));
      req[exp_own[n]] = 1'b0;
      tick();
      chk("rr_idle", 8'(busy), 8'h0);
      req = (n == 4) ? 4'b0000 : 4'b1111;
      tick();
    end
    req = 4'b0010;
    tick();
    chk("l1_gnt", 8'(gnt), 8'h2);
    req = 4'b0000;
    tick();
    req = 4'b0101;
    tick();
    chk("l1_pick", 8'(gnt), 8'h4);
    chk("l1_id", 8'(gnt_id), 8'h2);
    req = 4'b0000;
    tick();
    chk("l1_rel", 8'(gnt), 8'h0);
    req = 4'b0011;
    tick();
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 4; c++) begin
        chk("to_gnt", 8'(gnt), 8'(1 << to_own[n]));
        chk("to_low", 8'(timeout), 8'h0);
        if (n == 2) break;
        tick();
      end
      if (n == 2) break;
      chk("to_pulse", 8'(timeout), 8'h1);
      chk("to_revoke", 8'(gnt), 8'h0);
      chk("to_busy", 8'(busy), 8'h0);
      tick();
    end
    req = 4'b0000;
    tick();
    chk("to_end", 8'(gnt), 8'h0);
    req = 4'b0010;
    tick();
    chk("co_gnt", 8'(gnt), 8'h2);
    tick();
    tick();
    tick();
    chk("co_hold4", 8'(gnt), 8'h2);
    req = 4'b0000;
    tick();
    chk("co_to", 8'(timeout), 8'h0);
    chk("co_gnt0", 8'(gnt), 8'h0);
    tick();
    chk("co_to2", 8'(timeout), 8'h0);
    req = 4'b0100;
    tick();
    chk("ar_gnt", 8'(gnt), 8'h4);
    tick();
    reset_n = 1'b0;
    #1;
    chk("ar_gnt0", 8'(gnt), 8'h0);
    chk("ar_busy", 8'(busy), 8'h0);
    chk("ar_to", 8'(timeout), 8'h0);
    req = 4'b1001;
    tick();
    chk("ar_hold", 8'(gnt), 8'h0);
    reset_n = 1'b1;
    tick();
    chk("ar_pick", 8'(gnt), 8'h1);
    chk("ar_id", 8'(gnt_id), 8'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
